// File: rtl/dds_mem_reader_pkg.sv
// dds_mem_reader_pkg
// Shared definitions for the DDS sample-memory initiator:
//   - default widths (M address bits, N data bits, P phase bits) matching mem_read_file
//   - default read-wait and write-strobe lengths
//   - bus-sequencer state encoding
//   - helper that sizes the shared wait counter
package dds_mem_reader_pkg;

  localparam int DEF_M       = 3;
  localparam int DEF_N       = 4;
  localparam int DEF_P       = 8;
  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_CYC  = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_RD_CAP   = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_STB   = 3'd4,
    S_WR_REL   = 3'd5
  } state_t;

  // One down-counter serves both the read wait and the write strobe. It is
  // loaded with (length - 1), so it only has to hold max(length) - 1.
  function automatic int cnt_width(input int rd_wait, input int wr_cyc);
    int longest;
    longest = (rd_wait > wr_cyc) ? rd_wait : wr_cyc;
    return (longest > 2) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/dds_mem_reader_if.sv
// dds_mem_reader_if
// Control side of the sample-memory bus.
//   rd      : read strobe
//   wr      : write strobe
//   addr    : word address (M bits)
//   data_oe : high while the initiator owns the bidirectional data lines
// The data lines themselves are a plain inout port on the initiator so the
// tristate resolution stays at module boundaries.
// Modports: master (initiator drives everything), slave (memory/observer).
interface dds_mem_reader_if
  import dds_mem_reader_pkg::*;
#(
  parameter int M = DEF_M
);

  logic         rd;
  logic         wr;
  logic         data_oe;
  logic [M-1:0] addr;

  modport master (output rd, output wr, output data_oe, output addr);
  modport slave  (input rd, input wr, input data_oe, input addr);

endinterface

// File: rtl/dds_phase_acc.sv
// dds_phase_acc
// P-bit phase accumulator for the DDS reader. Adds tuning_word once per
// step and wraps modulo 2**P. The top M phase bits form the table address.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (phase clears to 0)
//   step        : advance the phase by tuning_word on this clock
//   tuning_word : phase increment, sampled only when step is high
//   phase_addr  : phase[P-1:P-M], the waveform table address
module dds_phase_acc
  import dds_mem_reader_pkg::*;
#(
  parameter int P = DEF_P,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic [P-1:0] tuning_word,
  output logic [M-1:0] phase_addr
);

  logic [P-1:0] phase;

  // Natural P-bit overflow gives the modulo-2**P wrap with no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (step) begin
      phase <= phase + tuning_word;
    end
  end

  assign phase_addr = phase[P-1:P-M];

endmodule

// File: rtl/dds_mem_reader.sv
// dds_mem_reader
// Bus initiator for the DDS waveform sample memory. Steps a phase
// accumulator and reads one sample per step into a registered output, and
// offers a single-word write path for patching the table at run time.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : free-run enable, starts a read whenever seen in IDLE
//   tuning_word       : phase increment, taken at the end of each read
//   load_req          : level request to write load_data at load_addr
//   load_addr/data    : write address/data, captured when leaving IDLE
//   load_ack          : one-cycle pulse in the write release cycle
//   bus (master)      : rd, wr, addr, data_oe towards the memory
//   data              : bidirectional memory data, driven only while writing
//   sample            : last captured sample
//   sample_valid      : one-cycle pulse when sample has just updated
//   busy              : high in every state except IDLE
module dds_mem_reader
  import dds_mem_reader_pkg::*;
#(
  parameter int M       = DEF_M,
  parameter int N       = DEF_N,
  parameter int P       = DEF_P,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_CYC  = DEF_WR_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [P-1:0]           tuning_word,
  input  logic                   load_req,
  input  logic [M-1:0]           load_addr,
  input  logic [N-1:0]           load_data,
  output logic                   load_ack,
  dds_mem_reader_if.master       bus,
  inout  wire  [N-1:0]           data,
  output logic [N-1:0]           sample,
  output logic                   sample_valid,
  output logic                   busy
);

  localparam int CW = cnt_width(RD_WAIT, WR_CYC);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  addr_q;
  logic [N-1:0]  data_q;
  logic [M-1:0]  phase_addr;
  logic          step;
  logic          rd_o;
  logic          wr_o;
  logic          oe_o;

  dds_phase_acc #(
    .P (P),
    .M (M)
  ) u_phase_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step),
    .tuning_word (tuning_word),
    .phase_addr  (phase_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus Moore outputs. All strobes are decoded from the state
  // register, so rd and wr can never overlap and data is only released in
  // the three write states, none of which asserts rd.
  always_comb begin
    next_state   = state;
    rd_o         = 1'b0;
    wr_o         = 1'b0;
    oe_o         = 1'b0;
    sample_valid = 1'b0;
    load_ack     = 1'b0;
    step         = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // A pending write takes priority over the next read.
        if (load_req) begin
          next_state = S_WR_SETUP;
        end else if (en) begin
          next_state = S_RD;
        end
      end
      S_RD: begin
        rd_o = 1'b1;
        if (cnt == '0) begin
          next_state = S_RD_CAP;
        end
      end
      S_RD_CAP: begin
        sample_valid = 1'b1;
        step         = 1'b1;
        next_state   = S_IDLE;
      end
      S_WR_SETUP: begin
        oe_o       = 1'b1;
        next_state = S_WR_STB;
      end
      S_WR_STB: begin
        oe_o = 1'b1;
        wr_o = 1'b1;
        if (cnt == '0) begin
          next_state = S_WR_REL;
        end
      end
      S_WR_REL: begin
        oe_o       = 1'b1;
        load_ack   = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Address, write data and the wait counter are only loaded on IDLE exit
  // (or on the strobe entry for the write counter), which keeps addr stable
  // for the whole time rd or wr is high. The sample is captured on the last
  // rd cycle so it is already valid when sample_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      sample <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_req) begin
            addr_q <= load_addr;
            data_q <= load_data;
          end else if (en) begin
            addr_q <= phase_addr;
            cnt    <= RD_LAST;
          end
        end
        S_RD: begin
          if (cnt == '0) begin
            sample <= data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WR_SETUP: begin
          cnt <= WR_LAST;
        end
        S_WR_STB: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rd      = rd_o;
  assign bus.wr      = wr_o;
  assign bus.data_oe = oe_o;
  assign bus.addr    = addr_q;
  assign data        = oe_o ? data_q : {N{1'bz}};

endmodule

// File: tb/tb_dds_mem_reader.sv
// tb_dds_mem_reader
// Directed bench for dds_mem_reader with a behavioural sample memory
// (mem[i] = i after reset). A vector table drives the phase sweep; short
// hand-written sequences cover write timing, read-back, en drop mid-read,
// write/read contention and asynchronous reset during a write strobe.
module tb_dds_mem_reader;

  localparam int M       = 3;
  localparam int N       = 4;
  localparam int P       = 8;
  localparam int RD_WAIT = 2;
  localparam int WR_CYC  = 2;

  localparam int EV_RD    = 0;
  localparam int EV_VALID = 1;
  localparam int EV_ACK   = 2;
  localparam int EV_IDLE  = 3;

  typedef struct {
    logic [P-1:0] tw;
    logic [M-1:0] exp_addr;
    logic [N-1:0] exp_sample;
  } read_vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [P-1:0] tuning_word = '0;
  logic         load_req = 1'b0;
  logic [M-1:0] load_addr = '0;
  logic [N-1:0] load_data = '0;
  logic         load_ack;
  logic [N-1:0] sample;
  logic         sample_valid;
  logic         busy;
  wire  [N-1:0] data;

  logic [N-1:0] mem [2**M];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  read_vec_t    vecs [15];

  dds_mem_reader_if #(.M(M)) bus ();

  dds_mem_reader #(
    .M       (M),
    .N       (N),
    .P       (P),
    .RD_WAIT (RD_WAIT),
    .WR_CYC  (WR_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .tuning_word  (tuning_word),
    .load_req     (load_req),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_ack     (load_ack),
    .bus          (bus),
    .data         (data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory model: combinational read while rd is high, write on the clock
  // edge while wr is high, table reloaded with mem[i] = i during reset.
  assign data = bus.rd ? mem[bus.addr] : {N{1'bz}};

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**M; i++) mem[i] <= N'(i);
    end else if (bus.wr) begin
      mem[bus.addr] <= data;
    end
  end

  // Bus invariants checked on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.rd && bus.wr) begin
        failures++;
        $display("[TB] FAIL rd_wr_overlap: rd=%0b wr=%0b, required not both high", bus.rd, bus.wr);
      end
      checks++;
      if (bus.rd && bus.data_oe) begin
        failures++;
        $display("[TB] FAIL drive_during_rd: rd=%0b data_oe=%0b, required data_oe=0", bus.rd, bus.data_oe);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic [P-1:0] tw_v, input logic req_v,
                               input logic [M-1:0] addr_v, input logic [N-1:0] data_v);
    en          = en_v;
    tuning_word = tw_v;
    load_req    = req_v;
    load_addr   = addr_v;
    load_data   = data_v;
  endtask

  // Advances negedge by negedge until the selected event is seen or the
  // budget runs out; a timeout is reported as a failed comparison.
  task automatic waitFor(input string name, input int sel, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        EV_RD:    hit = bus.rd;
        EV_VALID: hit = sample_valid;
        EV_ACK:   hit = load_ack;
        default:  hit = !busy;
      endcase
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: no event within %0d cycles, required event seen", name, budget);
    end
  endtask

  initial begin
    int last_valid;
    int c0;
    int extra;
    logic exp_wr [4];
    logic exp_ack [4];

    // Sweep table: addr/sample expected for each read, and the tuning word
    // in force when that read's accumulator step happens.
    for (int i = 0; i < 8; i++) vecs[i] = '{8'h20, M'(i), N'(i)};
    vecs[8]  = '{8'h40, 3'd0, 4'd0};
    vecs[9]  = '{8'h40, 3'd2, 4'd2};
    vecs[10] = '{8'h40, 3'd4, 4'd4};
    vecs[11] = '{8'h40, 3'd6, 4'd6};
    vecs[12] = '{8'h00, 3'd0, 4'd0};
    vecs[13] = '{8'h00, 3'd0, 4'd0};
    vecs[14] = '{8'h20, 3'd0, 4'd0};
    exp_wr  = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_ack = '{1'b0, 1'b0, 1'b0, 1'b1};

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_rd", bus.rd, 0);
    checkOutput("rst_wr", bus.wr, 0);
    checkOutput("rst_addr", bus.addr, 0);
    checkOutput("rst_data_oe", bus.data_oe, 0);
    checkOutput("rst_sample", sample, 0);
    checkOutput("rst_sample_valid", sample_valid, 0);
    checkOutput("rst_load_ack", load_ack, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] phase sweep");
    applyStimulus(1'b1, vecs[0].tw, 1'b0, '0, '0);
    last_valid = 0;
    for (int i = 0; i < 15; i++) begin
      waitFor($sformatf("sweep%0d_rd", i), EV_RD, 12);
      checkOutput($sformatf("sweep%0d_addr", i), bus.addr, vecs[i].exp_addr);
      tuning_word = vecs[i].tw;
      waitFor($sformatf("sweep%0d_valid", i), EV_VALID, 12);
      checkOutput($sformatf("sweep%0d_sample", i), sample, vecs[i].exp_sample);
      if (i > 0) checkOutput($sformatf("sweep%0d_period", i), cyc - last_valid, RD_WAIT + 2);
      last_valid = cyc;
    end
    en = 1'b0;
    waitFor("sweep_idle", EV_IDLE, 8);
    checkOutput("sweep_idle_busy", busy, 0);

    $display("[TB] write addr 5 <- 0xA");
    applyStimulus(1'b0, 8'h80, 1'b1, 3'd5, 4'hA);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("wr_c%0d_wr", k + 1), bus.wr, exp_wr[k]);
      checkOutput($sformatf("wr_c%0d_ack", k + 1), load_ack, exp_ack[k]);
      checkOutput($sformatf("wr_c%0d_oe", k + 1), bus.data_oe, 1);
      checkOutput($sformatf("wr_c%0d_data", k + 1), data, 4'hA);
      checkOutput($sformatf("wr_c%0d_addr", k + 1), bus.addr, 5);
    end
    load_req = 1'b0;
    @(negedge clk);
    checkOutput("wr_after_oe", bus.data_oe, 0);
    checkOutput("wr_after_busy", busy, 0);
    checkOutput("wr_after_ack", load_ack, 0);

    $display("[TB] read back and en drop mid-read");
    applyStimulus(1'b1, 8'h80, 1'b0, '0, '0);
    waitFor("rb1_rd", EV_RD, 12);
    checkOutput("rb1_addr", bus.addr, 1);
    waitFor("rb1_valid", EV_VALID, 12);
    checkOutput("rb1_sample", sample, 1);
    waitFor("rb2_rd", EV_RD, 12);
    checkOutput("rb2_addr", bus.addr, 5);
    en = 1'b0;
    waitFor("rb2_valid", EV_VALID, 12);
    checkOutput("rb2_sample", sample, 4'hA);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (sample_valid || bus.rd) extra++;
    end
    checkOutput("endrop_extra_activity", extra, 0);
    checkOutput("endrop_busy", busy, 0);

    $display("[TB] load_req and en together");
    applyStimulus(1'b1, 8'h80, 1'b1, 3'd3, 4'h5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("cont_c%0d_rd", k + 1), bus.rd, 0);
      checkOutput($sformatf("cont_c%0d_wr", k + 1), bus.wr, exp_wr[k]);
      checkOutput($sformatf("cont_c%0d_ack", k + 1), load_ack, exp_ack[k]);
    end
    load_req = 1'b0;
    c0 = cyc;
    waitFor("cont_rd", EV_RD, 12);
    checkOutput("cont_rd_delay", cyc - c0, 2);
    checkOutput("cont_addr", bus.addr, 1);
    en = 1'b0;
    waitFor("cont_valid", EV_VALID, 12);
    checkOutput("cont_sample", sample, 1);
    waitFor("cont_idle", EV_IDLE, 8);

    $display("[TB] async reset during write strobe");
    applyStimulus(1'b0, 8'h20, 1'b1, 3'd6, 4'h9);
    @(negedge clk);
    @(negedge clk);
    checkOutput("arst_pre_wr", bus.wr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_wr", bus.wr, 0);
    checkOutput("arst_oe", bus.data_oe, 0);
    checkOutput("arst_addr", bus.addr, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_sample", sample, 0);
    load_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h20, 1'b0, '0, '0);
    waitFor("post_rst_rd0", EV_RD, 12);
    checkOutput("post_rst_addr0", bus.addr, 0);
    waitFor("post_rst_valid0", EV_VALID, 12);
    checkOutput("post_rst_sample0", sample, 0);
    waitFor("post_rst_rd1", EV_RD, 12);
    checkOutput("post_rst_addr1", bus.addr, 1);
    en = 1'b0;
    waitFor("post_rst_valid1", EV_VALID, 12);
    checkOutput("post_rst_sample1", sample, 1);
    waitFor("post_rst_idle", EV_IDLE, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
